spi_cmd_sequencer: RTL and testbench

Command queue and launcher directly upstream of the CPU_spi controller. Buffers up to DEPTH 16-bit SPI transactions written by the host and presents them one at a time on transaccion. For each one it pulses START_STB, then tracks the controller's CS line to detect transaction start and completion. It also counts completed transactions and flags controllers that never assert CS.

---
 rtl/spi_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - command FIFO and launch sequencer ahead of CPU_spi
// Queues host words, strobes each one into CPU_spi and follows CS for completion or start timeout.
module spi_cmd_sequencer #(
  parameter int DEPTH         = 4,
  parameter int STB_CYCLES    = 2,
  parameter int GAP_CYCLES    = 4,
  parameter int START_TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   wr_en,
  input  logic [15:0]            wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   CS,
  output logic [15:0]            transaccion,
  output logic                   START_STB,
  output logic                   busy,
  output logic [7:0]             done_count,
  output logic                   timeout_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (START_TIMEOUT > STB_CYCLES)
                      ? ((START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES)
                      : ((STB_CYCLES > GAP_CYCLES) ? STB_CYCLES : GAP_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] STB_LAST   = CW'(STB_CYCLES);
  localparam logic [CW-1:0] TO_LAST    = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_LOW,
    WAIT_HIGH,
    GAP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          stb_d;
  logic [15:0]   trans_d;
  logic [7:0]    done_d;
  logic          err_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign pop   = (state == LOAD);
  assign push  = wr_en && (!full || pop);
  assign full  = (count == FULL_LEVEL);
  assign empty = (count == '0);
  assign level = count;
  assign busy  = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      START_STB   <= 1'b0;
      transaccion <= 16'h0000;
      done_count  <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      START_STB   <= stb_d;
      transaccion <= trans_d;
      done_count  <= done_d;
      timeout_err <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    stb_d   = START_STB;
    trans_d = transaccion;
    done_d  = done_count;
    err_d   = timeout_err;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        trans_d = mem[rd_ptr];
        cnt_d   = '0;
        state_d = STROBE;
      end
      // The strobe register rises one edge after entering STROBE and falls on the WAIT_LOW entry edge.
      STROBE: begin
        if (cnt == STB_LAST) begin
          stb_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_LOW;
        end else begin
          stb_d = 1'b1;
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!CS) begin
          state_d = WAIT_HIGH;
        end else if (cnt == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (CS) begin
          done_d  = done_count + 8'd1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - self-checking bench for spi_cmd_sequencer
// Timeline model of the queue and launch rules, checked every cycle, plus directed literal checks.
module tb_spi_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int STB   = 2;
  localparam int GAP   = 4;
  localparam int TO    = 64;

  logic        CLK     = 1'b0;
  logic        RESET   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        full, empty, START_STB, busy, timeout_err, CS;
  logic [2:0]  level;
  logic [15:0] transaccion;
  logic [7:0]  done_count;

  logic        man_cs  = 1'b1;
  logic        resp_cs = 1'b1;
  logic        resp_en = 1'b0;
  int          resp_delay = 0;
  int          resp_len   = 1;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] launched[$];
  logic [15:0] w2 [4];

  logic [15:0] q[$];
  logic [15:0] exp_trans = 16'h0000;
  logic        exp_stb   = 1'b0;
  logic        exp_busy  = 1'b0;
  logic        exp_err   = 1'b0;
  logic [7:0]  exp_done  = 8'h00;
  logic        s_cs      = 1'b1;
  logic        m_abort   = 1'b0;

  assign CS = resp_en ? resp_cs : man_cs;

  always #5 CLK = ~CLK;

  spi_cmd_sequencer #(
    .DEPTH(DEPTH), .STB_CYCLES(STB), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .CS(CS),
    .transaccion(transaccion), .START_STB(START_STB), .busy(busy),
    .done_count(done_count), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic m_clear();
    q.delete();
    exp_trans = 16'h0000;
    exp_stb   = 1'b0;
    exp_busy  = 1'b0;
    exp_err   = 1'b0;
    exp_done  = 8'h00;
  endtask

  task automatic tick(input bit pop, output logic [15:0] head);
    bit do_push;
    head = 16'h0000;
    @(posedge CLK or negedge RESET);
    if (!RESET) begin
      m_abort = 1'b1;
      m_clear();
      return;
    end
    s_cs    = CS;
    do_push = wr_en && (q.size() < DEPTH || pop);
    if (pop) head = q.pop_front();
    if (do_push) q.push_back(wr_data);
  endtask

  task automatic run_one();
    logic [15:0] h;
    bit has, got;
    has = (q.size() != 0);
    tick(1'b0, h); if (m_abort) return;
    if (!has) return;
    exp_busy = 1'b1;
    tick(1'b1, h); if (m_abort) return;
    exp_trans = h;
    repeat (STB) begin
      tick(1'b0, h); if (m_abort) return;
      exp_stb = 1'b1;
    end
    tick(1'b0, h); if (m_abort) return;
    exp_stb = 1'b0;
    got = 1'b0;
    for (int k = 0; k < TO; k++) begin
      tick(1'b0, h); if (m_abort) return;
      if (!s_cs) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      exp_err = 1'b1;
    end else begin
      forever begin
        tick(1'b0, h); if (m_abort) return;
        if (s_cs) break;
      end
      exp_done = exp_done + 8'd1;
    end
    repeat (GAP) begin
      tick(1'b0, h); if (m_abort) return;
    end
    exp_busy = 1'b0;
  endtask

  initial begin
    forever begin
      if (!RESET) begin
        m_clear();
        @(posedge RESET);
      end
      m_abort = 1'b0;
      run_one();
    end
  end

  // ---------------- per-cycle compare and launch log ----------------
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        chk("level", int'(level), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("transaccion", int'(transaccion), int'(exp_trans));
        chk("START_STB", int'(START_STB), int'(exp_stb));
        chk("busy", int'(busy), int'(exp_busy));
        chk("done_count", int'(done_count), int'(exp_done));
        chk("timeout_err", int'(timeout_err), int'(exp_err));
        if (START_STB && !prev) launched.push_back(transaccion);
      end
      prev = START_STB;
    end
  end

  // ---------------- CS responder ----------------
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (resp_en && prev && !START_STB) begin
        repeat (resp_delay) @(negedge CLK);
        resp_cs = 1'b0;
        repeat (resp_len) @(negedge CLK);
        resp_cs = 1'b1;
      end
      prev = START_STB;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic push_word(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge CLK);
    wr_en   = 1'b0;
  endtask

  task automatic wait_fall(input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!(seen && !START_STB) && n < 60) begin
      @(negedge CLK);
      n++;
      if (START_STB) seen = 1'b1;
    end
    chk(nm, int'(seen && !START_STB), 1);
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n;
    n = 0;
    while ((busy || !empty) && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, int'(busy || !empty), 0);
  endtask

  initial begin
    int n, h, b, t, base, cnt_ff;
    w2 = '{16'h0305, 16'h0601, 16'hAAAA, 16'h5555};

    repeat (3) @(negedge CLK);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_trans", int'(transaccion), 0);
    chk("rst_stb", int'(START_STB), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_count), 0);
    chk("rst_err", int'(timeout_err), 0);
    RESET = 1'b1;

    // single command
    push_word(16'h0305);
    n = 1;
    while (!START_STB && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("t1_stb_latency", n - 1, 3);
    h = 0;
    while (START_STB && h < 20) begin
      h++;
      @(negedge CLK);
    end
    chk("t1_stb_width", h, 2);
    chk("t1_trans", int'(transaccion), 16'h0305);
    repeat (3) @(negedge CLK);
    man_cs = 1'b0;
    repeat (40) @(negedge CLK);
    chk("t1_busy_in_xfer", int'(busy), 1);
    man_cs = 1'b1;
    @(posedge CLK);
    #1;
    b = 0;
    while (busy && b < 20) begin
      @(posedge CLK);
      #1;
      b++;
    end
    chk("t1_busy_fall", b, 4);
    chk("t1_done", int'(done_count), 1);
    chk("t1_empty", int'(empty), 1);
    chk("t1_trans_hold", int'(transaccion), 16'h0305);
    @(negedge CLK);

    // back-to-back fill behind a stalled holder transaction
    base = launched.size();
    push_word(16'h0001);
    wait_fall("t2_hold_launch");
    man_cs = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = w2[i];
      @(negedge CLK);
    end
    wr_en = 1'b0;
    chk("t2_level4", int'(level), 4);
    chk("t2_full", int'(full), 1);
    push_word(16'hFFFF);
    chk("t2_drop_level", int'(level), 4);
    resp_delay = 3;
    resp_len   = 5;
    resp_en    = 1'b1;
    man_cs     = 1'b1;
    wait_idle(400, "t2_drain");
    chk("t2_launches", launched.size() - base, 5);
    if (launched.size() - base == 5) begin
      for (int i = 0; i < 4; i++) chk("t2_order", int'(launched[base + 1 + i]), int'(w2[i]));
    end
    cnt_ff = 0;
    for (int i = base; i < launched.size(); i++) if (launched[i] == 16'hFFFF) cnt_ff++;
    chk("t2_no_ffff", cnt_ff, 0);
    chk("t2_done", int'(done_count), 6);

    // simultaneous push and pop while full
    resp_en = 1'b0;
    base = launched.size();
    push_word(16'h0002);
    wait_fall("t3_hold_launch");
    man_cs = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'h1111 * 16'(i + 1);
      @(negedge CLK);
    end
    wr_en = 1'b0;
    chk("t3_level4", int'(level), 4);
    resp_delay = 1;
    resp_len   = 2;
    resp_en    = 1'b1;
    man_cs     = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("t3_idle_seen", int'(busy), 0);
    @(negedge CLK);
    chk("t3_load_level", int'(level), 4);
    push_word(16'hBEEF);
    chk("t3_level_after", int'(level), 4);
    chk("t3_full_after", int'(full), 1);
    wait_idle(400, "t3_drain");
    chk("t3_launches", launched.size() - base, 6);
    if (launched.size() - base == 6) begin
      chk("t3_first", int'(launched[base + 1]), 16'h1111);
      chk("t3_last", int'(launched[base + 5]), 16'hBEEF);
    end
    chk("t3_done", int'(done_count), 12);

    // async reset during WAIT_HIGH with two queued entries
    resp_en = 1'b0;
    push_word(16'h0003);
    wait_fall("t4_launch");
    man_cs = 1'b0;
    repeat (2) @(negedge CLK);
    push_word(16'h0004);
    push_word(16'h0005);
    chk("t4_level2", int'(level), 2);
    chk("t4_busy", int'(busy), 1);
    chk("t4_done_before", int'(done_count), 12);
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    chk("t4_stb", int'(START_STB), 0);
    chk("t4_busy_rst", int'(busy), 0);
    chk("t4_level_rst", int'(level), 0);
    chk("t4_empty_rst", int'(empty), 1);
    chk("t4_done_rst", int'(done_count), 0);
    chk("t4_err_rst", int'(timeout_err), 0);
    chk("t4_trans_rst", int'(transaccion), 0);
    @(negedge CLK);
    RESET  = 1'b1;
    man_cs = 1'b1;

    // start timeout with CS tied high
    push_word(16'h1234);
    wait_fall("t5_launch");
    t = 0;
    while (!timeout_err && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("t5_timeout_cycles", t, 64);
    chk("t5_done", int'(done_count), 0);
    wait_idle(20, "t5_idle");
    chk("t5_empty", int'(empty), 1);
    chk("t5_err_sticky", int'(timeout_err), 1);

    // done_count wrap after 256 completions
    RESET = 1'b0;
    @(negedge CLK);
    chk("t6_err_cleared", int'(timeout_err), 0);
    RESET      = 1'b1;
    resp_delay = 0;
    resp_len   = 1;
    resp_en    = 1'b1;
    base = launched.size();
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (full && n < 100) begin
        @(negedge CLK);
        n++;
      end
      push_word(16'(i));
    end
    wait_idle(4000, "t6_drain");
    chk("t6_launches", launched.size() - base, 256);
    if (launched.size() - base == 256) begin
      chk("t6_mid", int'(launched[base + 128]), 16'h0080);
      chk("t6_last", int'(launched[base + 255]), 16'h00FF);
    end
    chk("t6_done_wrap", int'(done_count), 0);
    chk("t6_err", int'(timeout_err), 0);

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
